cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the existing single-cycle datapath (decoder, control, alu,
//  branch_compare, regfile) over a wait-state instruction/data memory bus. Owns PC and IR, walks
//  FETCH->DECODE->EXEC->[MEM]->WB, gates register/memory writes to single-cycle strobes, and halts
//  on ECALL, illegal opcode or bus timeout. Sits between top-level memory and the execute stage.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  TIMEOUT     16             max wait cycles for imem/dmem ready before bus error (>=1)
//  CNT_W       32             width of retired-instruction counter
//  HALT_ECALL  1              1: ECALL enters HALT; 0: ECALL treated as no-op
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  imem_req     out  1      instruction fetch request, addr = pc
//  imem_ready   in   1      fetch data valid this cycle
//  imem_rdata   in   32     fetched instruction
//  dmem_req     out  1      data access request (addr/wdata from datapath)
//  dmem_we      out  1      1 = store, 0 = load; valid only with dmem_req
//  dmem_ready   in   1      data access complete this cycle
//  ctl_mem_rw   in   1      control MemRW (1 = read, 0 = write)
//  ctl_reg_wen  in   1      control RegWEn
//  pc_next      in   32     next PC from datapath PCSel mux
//  pc           out  32     architectural PC
//  ir           out  32     instruction register, feeds decoder
//  reg_we       out  1      regfile write strobe
//  halted       out  1      sticky halt indicator
//  halt_cause   out  2      0 none, 1 ecall, 2 illegal opcode, 3 bus timeout
//  instret      out  CNT_W  retired instruction count
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, ir=32'h0000_0013, instret=0, halted=0,
//   halt_cause=0, wait counter=0. Strobes imem_req/dmem_req/dmem_we/reg_we are Moore decodes of state.
//  FETCH: imem_req=1. On imem_ready: ir<=imem_rdata, ->DECODE. Else wait counter++.
//  DECODE: 1 cycle, regfile read/control settle. opcode=ir[6:0]; not a known `OP_*` -> HALT, cause 2.
//  EXEC: 1 cycle, ALU/branch compare settle. LOAD or STORE -> MEM; else -> WB.
//  MEM: dmem_req=1, dmem_we=~ctl_mem_rw. On dmem_ready -> WB; else wait counter++.
//  WB: reg_we=ctl_reg_wen for exactly this cycle; pc<=pc_next; instret<=instret+1 (wraps mod 2^CNT_W);
//   -> FETCH, or -> HALT cause 1 if opcode ECALL and HALT_ECALL=1 (ECALL still retires, pc advances).
//  HALT: all strobes 0, pc/ir/instret frozen, halted=1; exits only on reset.
//  Wait counter: cleared on every state entry; ready seen on the cycle count reaches TIMEOUT wins;
//   count==TIMEOUT without ready -> HALT, cause 3, pc unchanged, no write strobes issued.
//  Latency (zero-wait bus): ALU/branch/jump = 4 cycles, load/store = 5; each wait cycle adds 1.
//  reg_we and dmem_req never asserted outside WB/MEM; stores never pulse reg_we (ctl_reg_wen=0).
//  imem_ready/dmem_ready outside their request states are ignored.
//  Reset mid-access: request drops immediately (async); bus must tolerate abandoned request.
// STRUCTURE
//  Shared header (seq_defs.vh): state encoding SEQ_FETCH/DECODE/EXEC/MEM/WB/HALT (3 bit),
//   HALT_* cause codes, IR reset NOP constant. Opcode macros reused from decoder.v `OP_*.
//  One sub-module: bus_timeout (clear, enable, TIMEOUT param -> expired); FSM, PC, IR, instret in top.
// TESTING
//  1. Reset, zero-wait imem holding addi x1,x0,5 -> imem_req at cycle 0, reg_we pulse cycle 3, pc=4.
//  2. sw then lw, dmem_ready after 2 waits -> dmem_we=1 then 0, each MEM 3 cycles, instret=2, no reg_we on sw.
//  3. beq taken with pc_next=0x40 -> pc=0x40 after WB, reg_we=0, 4 cycles.
//  4. imem_ready held low TIMEOUT cycles -> halted=1, halt_cause=3, pc unchanged, no strobes after.
//  5. ir=32'h0000_0073 (ECALL) -> halted=1, cause 1, instret incremented; opcode 7'h7f -> cause 2.
//  6. rst_n low mid-MEM -> dmem_req drops same cycle; after release pc=RESET_PC, instret=0.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state encoding, halt causes,
// RV32I major opcodes and the reset value of the instruction register.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_EXEC   = 3'd2,
        SEQ_MEM    = 3'd3,
        SEQ_WB     = 3'd4,
        SEQ_HALT   = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE        = 2'd0,
        CAUSE_ECALL       = 2'd1,
        CAUSE_ILLEGAL     = 2'd2,
        CAUSE_BUS_TIMEOUT = 2'd3
    } halt_cause_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] IR_NOP = 32'h0000_0013;

    function automatic logic is_known_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_bus_timeout.sv
// Wait-state counter for one bus access: counts stalled cycles and flags when the
// count has reached TIMEOUT. Clear has priority and the count saturates at the limit.
module cpu_sequencer_bus_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer: walks FETCH->DECODE->EXEC->[MEM]->WB around a single-cycle
// datapath, owns PC/IR/instret, and halts on ECALL, illegal opcode or bus timeout.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned HALT_ECALL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             ctl_mem_rw,
    input  logic             ctl_reg_wen,
    input  logic [31:0]      pc_next,
    output logic [31:0]      pc,
    output logic [31:0]      ir,
    output logic             reg_we,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instret
);

    seq_state_e       state_q, state_d;
    halt_cause_e      cause_q, cause_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       wait_clear, wait_en, wait_expired;
    logic [6:0] opcode;

    assign opcode = ir_q[6:0];

    cpu_sequencer_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wait_clear),
        .enable_i  (wait_en),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        wait_en   = 1'b0;

        case (state_q)
            SEQ_FETCH: begin
                // Ready on the cycle the count hits TIMEOUT still wins over the timeout.
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = SEQ_DECODE;
                end else if (wait_expired) begin
                    state_d = SEQ_HALT;
                    cause_d = CAUSE_BUS_TIMEOUT;
                end else begin
                    wait_en = 1'b1;
                end
            end
            SEQ_DECODE: begin
                if (is_known_opcode(opcode)) begin
                    state_d = SEQ_EXEC;
                end else begin
                    state_d = SEQ_HALT;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            SEQ_EXEC: begin
                state_d = ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? SEQ_MEM : SEQ_WB;
            end
            SEQ_MEM: begin
                if (dmem_ready) begin
                    state_d = SEQ_WB;
                end else if (wait_expired) begin
                    state_d = SEQ_HALT;
                    cause_d = CAUSE_BUS_TIMEOUT;
                end else begin
                    wait_en = 1'b1;
                end
            end
            SEQ_WB: begin
                pc_d      = pc_next;
                instret_d = instret_q + CNT_W'(1);
                if ((HALT_ECALL != 0) && (opcode == OP_SYSTEM)) begin
                    state_d = SEQ_HALT;
                    cause_d = CAUSE_ECALL;
                end else begin
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_HALT: begin
                state_d = SEQ_HALT;
            end
            default: begin
                state_d = SEQ_HALT;
            end
        endcase

        wait_clear = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEQ_FETCH;
            cause_q   <= CAUSE_NONE;
            pc_q      <= RESET_PC;
            ir_q      <= IR_NOP;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req   = (state_q == SEQ_FETCH);
    assign dmem_req   = (state_q == SEQ_MEM);
    assign dmem_we    = (state_q == SEQ_MEM) && !ctl_mem_rw;
    assign reg_we     = (state_q == SEQ_WB) && ctl_reg_wen;
    assign halted     = (state_q == SEQ_HALT);
    assign halt_cause = cause_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign instret    = instret_q;

endmodule
